// File: rtl/id_stage_if.sv
// ID/EX pipeline-register bundle presented by the decode stage.
// The decode stage drives it (master); EX consumes it (slave).
interface id_stage_if;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        alu_src_pc;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic        illegal;

  modport master (
    output valid, pc, instr,
    output rs1_val, rs2_val, imm,
    output rd, rs1, rs2, funct3,
    output alu_op, alu_src_imm, alu_src_pc,
    output mem_read, mem_write, reg_write,
    output branch, jal, jalr, illegal
  );

  modport slave (
    input valid, pc, instr,
    input rs1_val, rs2_val, imm,
    input rd, rs1, rs2, funct3,
    input alu_op, alu_src_imm, alu_src_pc,
    input mem_read, mem_write, reg_write,
    input branch, jal, jalr, illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: decode, operand read with writeback bypass,
// load-use stall and flush handling, ID/EX pipeline register.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        flush,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  id_stage_if.master  ex
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } id_ex_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  id_ex_t      r_idex;
  id_ex_t      w_dec;
  id_ex_t      w_bub;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic        w_f7b5;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_use1;
  logic        w_use2;
  logic        w_wr;
  logic        w_haz;
  logic        w_is_lui;
  logic        w_is_auipc;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_br;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_imm;
  logic        w_is_reg;

  function automatic logic [3:0] alu_sel(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  assign w_opc    = if_instr[6:0];
  assign w_f3     = if_instr[14:12];
  assign w_f7b5   = if_instr[30];
  assign w_rd     = if_instr[11:7];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25],
                    if_instr[11:7]};
  assign w_imm_b = {{19{if_instr[31]}}, if_instr[31],
                    if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
  assign w_imm_u = {if_instr[31:12], 12'b0};
  assign w_imm_j = {{11{if_instr[31]}}, if_instr[31],
                    if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

  assign w_is_lui   = (w_opc == OP_LUI);
  assign w_is_auipc = (w_opc == OP_AUIPC);
  assign w_is_jal   = (w_opc == OP_JAL);
  assign w_is_jalr  = (w_opc == OP_JALR);
  assign w_is_br    = (w_opc == OP_BRANCH);
  assign w_is_ld    = (w_opc == OP_LOAD);
  assign w_is_st    = (w_opc == OP_STORE);
  assign w_is_imm   = (w_opc == OP_IMM);
  assign w_is_reg   = (w_opc == OP_REG);

  // Regfile returns the old value while it is being written.
  always_comb begin
    w_op1 = rs1_data;
    if (rs1_addr == 5'd0)
      w_op1 = '0;
    else if (wb_en && wb_addr == rs1_addr)
      w_op1 = wb_data;
  end

  always_comb begin
    w_op2 = rs2_data;
    if (rs2_addr == 5'd0)
      w_op2 = '0;
    else if (wb_en && wb_addr == rs2_addr)
      w_op2 = wb_data;
  end

  always_comb begin
    w_bub       = '0;
    w_bub.instr = NOP_INSTR;
  end

  always_comb begin
    w_dec         = '0;
    w_use1        = 1'b0;
    w_use2        = 1'b0;
    w_wr          = 1'b0;
    w_dec.valid   = 1'b1;
    w_dec.pc      = if_pc;
    w_dec.instr   = if_instr;
    w_dec.rd      = w_rd;
    w_dec.funct3  = w_f3;
    w_dec.rs1_val = w_op1;
    w_dec.rs2_val = w_op2;
    unique case (1'b1)
      w_is_lui: begin
        w_dec.imm         = w_imm_u;
        w_dec.alu_op      = ALU_PASS;
        w_dec.alu_src_imm = 1'b1;
        w_wr              = 1'b1;
      end
      w_is_auipc: begin
        w_dec.imm         = w_imm_u;
        w_dec.alu_src_imm = 1'b1;
        w_dec.alu_src_pc  = 1'b1;
        w_wr              = 1'b1;
      end
      w_is_jal: begin
        w_dec.imm         = w_imm_j;
        w_dec.alu_src_imm = 1'b1;
        w_dec.alu_src_pc  = 1'b1;
        w_dec.jal         = 1'b1;
        w_wr              = 1'b1;
      end
      w_is_jalr: begin
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.jalr        = 1'b1;
        w_use1            = 1'b1;
        w_wr              = 1'b1;
      end
      w_is_br: begin
        w_dec.imm    = w_imm_b;
        w_dec.alu_op = ALU_SUB;
        w_dec.branch = 1'b1;
        w_use1       = 1'b1;
        w_use2       = 1'b1;
      end
      w_is_ld: begin
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.mem_read    = 1'b1;
        w_use1            = 1'b1;
        w_wr              = 1'b1;
      end
      w_is_st: begin
        w_dec.imm         = w_imm_s;
        w_dec.alu_src_imm = 1'b1;
        w_dec.mem_write   = 1'b1;
        w_use1            = 1'b1;
        w_use2            = 1'b1;
      end
      w_is_imm: begin
        w_dec.imm         = w_imm_i;
        w_dec.alu_op      = alu_sel(w_f3,
                              w_f7b5 && w_f3 == 3'b101);
        w_dec.alu_src_imm = 1'b1;
        w_use1            = 1'b1;
        w_wr              = 1'b1;
      end
      w_is_reg: begin
        w_dec.alu_op = alu_sel(w_f3, w_f7b5);
        w_use1       = 1'b1;
        w_use2       = 1'b1;
        w_wr         = 1'b1;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.reg_write = w_wr && (w_rd != 5'd0);
    w_dec.rs1       = w_use1 ? rs1_addr : 5'd0;
    w_dec.rs2       = w_use2 ? rs2_addr : 5'd0;
  end

  // Only used sources can collide with a load in EX.
  assign w_haz = r_idex.valid && r_idex.mem_read &&
                 (r_idex.rd != 5'd0) &&
                 ((w_use1 && r_idex.rd == rs1_addr) ||
                  (w_use2 && r_idex.rd == rs2_addr)) &&
                 if_valid && !flush;

  assign stall = w_haz;

  always_ff @(posedge clk) begin
    if (rst)
      r_idex <= w_bub;
    else if (flush || !if_valid || w_haz)
      r_idex <= w_bub;
    else
      r_idex <= w_dec;
  end

  assign ex.valid       = r_idex.valid;
  assign ex.pc          = r_idex.pc;
  assign ex.instr       = r_idex.instr;
  assign ex.rs1_val     = r_idex.rs1_val;
  assign ex.rs2_val     = r_idex.rs2_val;
  assign ex.imm         = r_idex.imm;
  assign ex.rd          = r_idex.rd;
  assign ex.rs1         = r_idex.rs1;
  assign ex.rs2         = r_idex.rs2;
  assign ex.funct3      = r_idex.funct3;
  assign ex.alu_op      = r_idex.alu_op;
  assign ex.alu_src_imm = r_idex.alu_src_imm;
  assign ex.alu_src_pc  = r_idex.alu_src_pc;
  assign ex.mem_read    = r_idex.mem_read;
  assign ex.mem_write   = r_idex.mem_write;
  assign ex.reg_write   = r_idex.reg_write;
  assign ex.branch      = r_idex.branch;
  assign ex.jal         = r_idex.jal;
  assign ex.jalr        = r_idex.jalr;
  assign ex.illegal     = r_idex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued
// at issue time and checked by a monitor one edge later.
module tb_id_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [3:0]  op;
    logic        simm;
    logic        mr;
    logic        rw;
    logic        br;
    logic        ill;
  } exp_t;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ADD312 = 32'h002081B3;
  localparam logic [31:0] ADDIM1 = 32'hFFF00293;
  localparam logic [31:0] BEQM4  = 32'hFE208EE3;
  localparam logic [31:0] LW41   = 32'h0000A203;
  localparam logic [31:0] ADD642 = 32'h00220333;
  localparam logic [31:0] ADD652 = 32'h00228333;
  localparam logic [31:0] BADOP  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = NOP;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        stall;

  id_stage_if exi ();

  id_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall),
    .ex(exi.master)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_err = 0;
  exp_t  sb[$];
  string sb_nm[$];

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    e.instr = NOP;
    return e;
  endfunction

  function automatic exp_t mk(
    input logic [31:0] ins, a, b, imm,
    input logic [4:0]  rd, s1, s2,
    input logic [3:0]  op,
    input logic simm, mr, rw, br, ill
  );
    exp_t e;
    e = '{v: 1'b1, instr: ins, a: a, b: b, imm: imm,
          rd: rd, s1: s1, s2: s2, op: op, simm: simm,
          mr: mr, rw: rw, br: br, ill: ill};
    return e;
  endfunction

  task automatic drive(
    input string nm,
    input logic r, fl, vld,
    input logic [31:0] ins, d1, d2,
    input logic we,
    input logic [4:0] wa,
    input logic [31:0] wd,
    input exp_t e
  );
    @(negedge clk);
    #1;
    rst = r;
    flush = fl;
    if_valid = vld;
    if_instr = ins;
    if_pc = if_pc + 32'd4;
    rs1_data = d1;
    rs2_data = d2;
    wb_en = we;
    wb_addr = wa;
    wb_data = wd;
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic chk_stall(input logic x, input string nm);
    #1;
    n_chk++;
    if (stall !== x) begin
      n_err++;
      $display("FAIL %s: stall=%0b expected %0b", nm, stall, x);
    end
  endtask

  // Monitor: compares the registered ID/EX bundle each cycle.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  act;
    string nm;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      act = '{v: exi.valid, instr: exi.instr,
              a: exi.rs1_val, b: exi.rs2_val,
              imm: exi.imm, rd: exi.rd, s1: exi.rs1,
              s2: exi.rs2, op: exi.alu_op,
              simm: exi.alu_src_imm, mr: exi.mem_read,
              rw: exi.reg_write, br: exi.branch,
              ill: exi.illegal};
      n_chk++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive("reset", 1, 0, 0, NOP, 0, 0, 0, 0, 0, bub());
    chk_stall(0, "stall_reset");

    drive("add", 0, 0, 1, ADD312, 10, 20, 0, 0, 0,
          mk(ADD312, 10, 20, 0, 3, 1, 2, 0, 0, 0, 1, 0, 0));
    drive("addi_m1", 0, 0, 1, ADDIM1, 123, 0, 0, 0, 0,
          mk(ADDIM1, 0, 0, 32'hFFFFFFFF, 5, 0, 0, 0,
             1, 0, 1, 0, 0));
    drive("beq_m4", 0, 0, 1, BEQM4, 5, 6, 0, 0, 0,
          mk(BEQM4, 5, 6, 32'hFFFFFFFC, 29, 1, 2, 1,
             0, 0, 0, 1, 0));
    drive("bypass", 0, 0, 1, ADD312, 10, 20, 1, 1, 32'h55,
          mk(ADD312, 32'h55, 20, 0, 3, 1, 2, 0, 0, 0, 1, 0, 0));
    drive("bypass_x0", 0, 0, 1, ADD312, 10, 20, 1, 0, 32'h55,
          mk(ADD312, 10, 20, 0, 3, 1, 2, 0, 0, 0, 1, 0, 0));

    drive("lw", 0, 0, 1, LW41, 32'h1000, 0, 0, 0, 0,
          mk(LW41, 32'h1000, 0, 0, 4, 1, 0, 0, 1, 1, 1, 0, 0));
    drive("lu_bubble", 0, 0, 1, ADD642, 0, 0, 0, 0, 0, bub());
    chk_stall(1, "stall_loaduse");
    drive("lu_add", 0, 0, 1, ADD642, 32'h11, 32'h22, 0, 0, 0,
          mk(ADD642, 32'h11, 32'h22, 0, 6, 4, 2, 0,
             0, 0, 1, 0, 0));
    chk_stall(0, "stall_released");

    drive("lw2", 0, 0, 1, LW41, 32'h2000, 0, 0, 0, 0,
          mk(LW41, 32'h2000, 0, 0, 4, 1, 0, 0, 1, 1, 1, 0, 0));
    drive("nodep_add", 0, 0, 1, ADD652, 3, 4, 0, 0, 0,
          mk(ADD652, 3, 4, 0, 6, 5, 2, 0, 0, 0, 1, 0, 0));
    chk_stall(0, "stall_nodep");

    drive("lw3", 0, 0, 1, LW41, 32'h3000, 0, 0, 0, 0,
          mk(LW41, 32'h3000, 0, 0, 4, 1, 0, 0, 1, 1, 1, 0, 0));
    drive("flush_bub", 0, 1, 1, ADD642, 7, 8, 0, 0, 0, bub());
    chk_stall(0, "stall_flush");
    drive("invalid_bub", 0, 0, 0, ADD312, 1, 2, 0, 0, 0, bub());
    chk_stall(0, "stall_invalid");

    drive("illegal", 0, 0, 1, BADOP, 9, 9, 0, 0, 0,
          mk(BADOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    drive("lw4", 0, 0, 1, LW41, 32'h4000, 0, 0, 0, 0,
          mk(LW41, 32'h4000, 0, 0, 4, 1, 0, 0, 1, 1, 1, 0, 0));
    drive("rst_mid", 1, 0, 1, ADD642, 5, 6, 0, 0, 0, bub());
    chk_stall(1, "stall_before_rst");
    drive("after_rst", 0, 0, 1, ADD642, 32'h31, 32'h32, 0, 0, 0,
          mk(ADD642, 32'h31, 32'h32, 0, 6, 4, 2, 0,
             0, 0, 1, 0, 0));
    chk_stall(0, "stall_after_rst");

    drive("idle", 0, 0, 0, NOP, 0, 0, 0, 0, 0, bub());
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
